// File: rtl/ps2_rx.sv
// Host-side PS/2 device-to-host frame receiver with glitch filter,
// parity/stop checking and an inactivity timeout.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    input  logic       Enable,
    output logic [7:0] Data,
    output logic       Done,
    output logic       ParityError,
    output logic       FrameError,
    output logic       Idle
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] FL_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        st_idle,
        st_receive,
        st_check
    } state_e;

    state_e        state_q, state_d;
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d, filt_dly_q, filt_dly_d;
    logic          fall_tick_q, fall_tick_d;
    logic [7:0]    run_cnt_q, run_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d, shift_nxt;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          idle_q, idle_d;

    always_comb begin
        clk_s1_d    = PS2Clk;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = PS2Data;
        dat_s2_d    = dat_s1_q;
        filt_d      = filt_q;
        run_cnt_d   = '0;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        data_d      = data_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        shift_nxt   = {dat_s2_q, shift_q[9:1]};

        // Run-length filter: the level flips only after a full run
        if (clk_s2_q != filt_q) begin
            if (run_cnt_q == FL_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                run_cnt_d = run_cnt_q + 8'd1;
            end
        end
        filt_dly_d  = filt_q;
        fall_tick_d = filt_dly_q & ~filt_q;

        if (!Enable) begin
            state_d   = st_idle;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
        end else begin
            unique case (state_q)
                st_idle: begin
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    if (fall_tick_q && !dat_s2_q) begin
                        state_d = st_receive;
                    end
                end
                st_receive: begin
                    if (fall_tick_q) begin
                        shift_d   = shift_nxt;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        to_cnt_d  = '0;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = st_check;
                            done_d  = 1'b1;
                            data_d  = shift_nxt[7:0];
                            perr_d  = ~(^shift_nxt[8:0]);
                            ferr_d  = ~shift_nxt[9];
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = st_idle;
                        ferr_d  = 1'b1;
                        perr_d  = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
                st_check: begin
                    state_d = st_idle;
                end
                default: begin
                    state_d = st_idle;
                end
            endcase
        end

        idle_d = (state_d == st_idle);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_dly_q  <= 1'b1;
            fall_tick_q <= 1'b0;
            run_cnt_q   <= '0;
            state_q     <= st_idle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_dly_d;
            fall_tick_q <= fall_tick_d;
            run_cnt_q   <= run_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            data_q      <= data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            idle_q      <= idle_d;
        end
    end

    assign Data        = data_q;
    assign Done        = done_q;
    assign ParityError = perr_q;
    assign FrameError  = ferr_q;
    assign Idle        = idle_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table of frames through a scoreboard, plus glitch,
// timeout, enable-drop and mid-frame reset sequences.
module tb_ps2_rx;

    localparam int FL = 8;
    localparam int TO = 500;
    localparam int H  = 40;

    logic       Clk = 1'b0;
    logic       Reset, PS2Clk, PS2Data, Enable;
    logic [7:0] Data;
    logic       Done, ParityError, FrameError, Idle;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset(Reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
        .Enable(Enable), .Data(Data), .Done(Done),
        .ParityError(ParityError), .FrameError(FrameError), .Idle(Idle)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int last_fall = 0;

    typedef struct {
        logic [7:0] d; logic p; logic s;
        logic [7:0] ed; logic epe; logic efe;
    } vec_t;

    typedef struct {
        logic [7:0] d; logic pe; logic fe; int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset === 1'b1 && Done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got 1 expected 0 at cyc %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("data", {24'h0, Data}, {24'h0, mon_e.d});
                chk("parity_err", {31'h0, ParityError}, {31'h0, mon_e.pe});
                chk("frame_err", {31'h0, FrameError}, {31'h0, mon_e.fe});
                chk("done_latency", cyc, mon_e.due);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int glitch_bit, input logic [7:0] ed,
                             input logic epe, input logic efe,
                             input logic push);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            PS2Data = bits[i];
            if (i == glitch_bit) begin
                step(10);
                PS2Clk = 1'b0;
                step(5);
                PS2Clk = 1'b1;
                step(H - 15);
            end else begin
                step(H);
            end
            PS2Clk = 1'b0;
            last_fall = cyc;
            if (push && i == 10) begin
                e = '{ed, epe, efe, cyc + FL + 4};
                sb.push_back(e);
            end
            step(H);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int target;
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[3] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};

        Reset = 1'b0;
        PS2Clk = 1'b1;
        PS2Data = 1'b1;
        Enable = 1'b1;
        step(3);
        chk("rst_data", {24'h0, Data}, 32'h0);
        chk("rst_done", {31'h0, Done}, 32'h0);
        chk("rst_perr", {31'h0, ParityError}, 32'h0);
        chk("rst_ferr", {31'h0, FrameError}, 32'h0);
        chk("rst_idle", {31'h0, Idle}, 32'h1);
        Reset = 1'b1;
        step(20);

        for (int i = 0; i < 4; i++) begin
            send_bits({tbl[i].s, tbl[i].p, tbl[i].d, 1'b0}, 11, -1,
                      tbl[i].ed, tbl[i].epe, tbl[i].efe, 1'b1);
            drain("frame_done");
            chk("idle_after", {31'h0, Idle}, 32'h1);
            step(20);
        end

        // Idle glitch with data low: a leaked tick would start a frame
        PS2Data = 1'b0;
        PS2Clk = 1'b0;
        step(5);
        PS2Clk = 1'b1;
        step(20);
        PS2Data = 1'b1;
        chk("idle_glitch", {31'h0, Idle}, 32'h1);
        step(20);
        send_bits({1'b1, 1'b1, 8'h81, 1'b0}, 11, 3, 8'h81, 1'b0, 1'b0, 1'b1);
        drain("glitch_frame");
        step(20);

        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, -1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("idle_mid", {31'h0, Idle}, 32'h0);
        target = last_fall + FL + 3 + TO;
        do @(negedge Clk); while (cyc < target);
        chk("to_early", {31'h0, FrameError}, 32'h0);
        @(negedge Clk);
        chk("to_ferr", {31'h0, FrameError}, 32'h1);
        chk("to_perr", {31'h0, ParityError}, 32'h0);
        chk("to_idle", {31'h0, Idle}, 32'h1);
        chk("to_data", {24'h0, Data}, 32'h81);
        step(20);

        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 6, -1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(5);
        chk("en_busy", {31'h0, Idle}, 32'h0);
        Enable = 1'b0;
        step(1);
        chk("en_idle", {31'h0, Idle}, 32'h1);
        chk("en_ferr", {31'h0, FrameError}, 32'h1);
        chk("en_perr", {31'h0, ParityError}, 32'h0);
        chk("en_data", {24'h0, Data}, 32'h81);
        step(10);
        Enable = 1'b1;
        step(20);

        send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 4, -1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(3);
        chk("rst_busy", {31'h0, Idle}, 32'h0);
        Reset = 1'b0;
        #1;
        chk("mrst_data", {24'h0, Data}, 32'h0);
        chk("mrst_done", {31'h0, Done}, 32'h0);
        chk("mrst_perr", {31'h0, ParityError}, 32'h0);
        chk("mrst_ferr", {31'h0, FrameError}, 32'h0);
        chk("mrst_idle", {31'h0, Idle}, 32'h1);
        step(3);
        Reset = 1'b1;
        step(20);
        send_bits({1'b1, 1'b1, 8'hFA, 1'b0}, 11, -1, 8'hFA, 1'b0, 1'b0, 1'b1);
        drain("final_frame");
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
